multicycle_control: RTL

//  Multi-cycle RV32I(+M) main control FSM: next generation of the single-cycle opcode decoder.

---
 rtl/multicycle_control_pkg.sv | 68 ++++++
 rtl/multicycle_control_muldiv_timer.sv | 41 ++++
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I(+M) control FSM:
// opcode constants, FSM state and instruction-class enums, datapath mux
// encodings, and the opcode decode helper used in S_DECODE.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASSB  = 2'b11;

  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC4     = 2'b10;
  localparam logic [1:0] WB_PCIMM   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MULDIV, S_WB, S_TRAP
  } state_t;

  // Instruction class steers the EXEC/MEM branching of the FSM.
  typedef enum logic [2:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_MULDIV
  } cls_t;

  typedef struct packed {
    logic       legal;
    cls_t       cls;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] wsrc;
    logic       jal;
    logic       jalr;
    logic       auipc;
  } dec_t;

  // Mul/div selection depends on funct7 and a parameter, so it is resolved
  // by the caller; OP is reported here as a plain ALU class.
  function automatic dec_t decode_opcode(input logic [6:0] opc);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    d.cls   = CL_ALU;
    case (opc)
      OPC_LOAD:   begin d.cls = CL_LOAD;  d.alu_src = 1'b1; d.wsrc = WB_MEM; end
      OPC_STORE:  begin d.cls = CL_STORE; d.alu_src = 1'b1; end
      OPC_OP_IMM: begin d.alu_src = 1'b1; d.alu_op = ALU_FUNCT; end
      OPC_OP:     d.alu_op = ALU_FUNCT;
      OPC_BRANCH: begin d.cls = CL_BRANCH; d.alu_op = ALU_BRANCH; end
      OPC_JAL:    begin d.jal = 1'b1; d.wsrc = WB_PC4; end
      OPC_JALR:   begin d.jalr = 1'b1; d.alu_src = 1'b1; d.wsrc = WB_PC4; end
      OPC_AUIPC:  begin d.auipc = 1'b1; d.alu_src = 1'b1; d.wsrc = WB_PCIMM; end
      OPC_LUI:    begin d.alu_src = 1'b1; d.alu_op = ALU_PASSB; end
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_control_muldiv_timer.sv
// Loadable down-counter that times the iterative mul/div phase.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load CYCLES-1 (issued on the EXEC cycle before S_MULDIV)
//   i_en         : count down (asserted while in S_MULDIV)
//   o_first      : high during the first counting cycle after a load
//   o_done       : counter has reached zero (terminal count)
module multicycle_control_muldiv_timer #(
  parameter int unsigned CYCLES = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_first,
  output logic o_done
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          r_first;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_first <= 1'b0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
      r_first <= 1'b1;
    end else if (i_en) begin
      r_first <= 1'b0;
      if (r_count != '0) r_count <= r_count - CW'(1);
    end
  end

  assign o_first = r_first;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I(+M) main control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB
// over a shared datapath with ready handshakes to instruction/data memory.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_opcode, i_funct7_0: IR fields, sampled only in S_DECODE
//   i_imem_ready        : instruction memory done
//   i_dmem_ready        : data memory access complete
//   o_imem_req, o_ir_write, o_dmem_read, o_dmem_write : memory handshake
//   o_alu_src, o_alu_op, o_regwrite_src, o_jal, o_jalr, o_auipc : decoded
//                         controls, registered in S_DECODE, held to retire
//   o_branch, o_reg_write, o_pc_write, o_muldiv_start : per-state pulses
//   o_illegal_instr     : sticky unknown-opcode flag
//   o_retire_count      : retired-instruction counter (wraps)
//
// state    | meaning
// S_FETCH  | request instruction until imem ready, pulse ir_write
// S_DECODE | register decoded controls; unknown opcode -> S_TRAP
// S_EXEC   | ALU cycle; branches retire here
// S_MEM    | load/store handshake; stores retire on dmem ready
// S_MULDIV | iterative mul/div, MULDIV_CYCLES cycles
// S_WB     | register write and retire
// S_TRAP   | illegal opcode, everything idle until reset
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit          ENABLE_MULDIV = 1'b1,
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned RETIRE_W      = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [6:0]          i_opcode,
  input  logic                i_funct7_0,
  input  logic                i_imem_ready,
  input  logic                i_dmem_ready,
  output logic                o_imem_req,
  output logic                o_ir_write,
  output logic                o_dmem_read,
  output logic                o_dmem_write,
  output logic                o_alu_src,
  output logic [1:0]          o_alu_op,
  output logic                o_branch,
  output logic                o_jal,
  output logic                o_jalr,
  output logic                o_auipc,
  output logic [1:0]          o_regwrite_src,
  output logic                o_reg_write,
  output logic                o_pc_write,
  output logic                o_muldiv_start,
  output logic                o_illegal_instr,
  output logic [RETIRE_W-1:0] o_retire_count
);

  state_t r_state, w_next;
  cls_t   r_cls;
  logic   r_alu_src, r_jal, r_jalr, r_auipc, r_illegal;
  logic [1:0] r_alu_op, r_wsrc;
  logic [RETIRE_W-1:0] r_retire_count;
  dec_t   w_dec;
  logic   w_md_load, w_md_first, w_md_done;

  assign w_dec     = decode_opcode(i_opcode);
  assign w_md_load = (r_state == S_EXEC) && (r_cls == CL_MULDIV);

  multicycle_control_muldiv_timer #(.CYCLES(MULDIV_CYCLES)) u_muldiv_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_md_load),
    .i_en    (r_state == S_MULDIV),
    .o_first (w_md_first),
    .o_done  (w_md_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (i_imem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_dec.legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (r_cls)
          CL_BRANCH:         w_next = S_FETCH;
          CL_LOAD, CL_STORE: w_next = S_MEM;
          CL_MULDIV:         w_next = S_MULDIV;
          default:           w_next = S_WB;
        endcase
      end
      S_MEM:    if (i_dmem_ready) w_next = (r_cls == CL_LOAD) ? S_WB : S_FETCH;
      S_MULDIV: if (w_md_done) w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // Pulses are forced low while reset is held so nothing is requested then.
  always_comb begin
    o_imem_req     = 1'b0;
    o_ir_write     = 1'b0;
    o_dmem_read    = 1'b0;
    o_dmem_write   = 1'b0;
    o_branch       = 1'b0;
    o_reg_write    = 1'b0;
    o_pc_write     = 1'b0;
    o_muldiv_start = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          o_ir_write = i_imem_ready;
        end
        S_EXEC: begin
          o_branch   = (r_cls == CL_BRANCH);
          o_pc_write = (r_cls == CL_BRANCH);
        end
        S_MEM: begin
          o_dmem_read  = (r_cls == CL_LOAD);
          o_dmem_write = (r_cls == CL_STORE);
          o_pc_write   = (r_cls == CL_STORE) && i_dmem_ready;
        end
        S_MULDIV: o_muldiv_start = w_md_first;
        S_WB: begin
          o_reg_write = 1'b1;
          o_pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Decoded controls load in DECODE and are cleared at retire so they are
  // only asserted for the instruction that owns them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cls          <= CL_ALU;
      r_alu_src      <= 1'b0;
      r_alu_op       <= 2'b00;
      r_wsrc         <= 2'b00;
      r_jal          <= 1'b0;
      r_jalr         <= 1'b0;
      r_auipc        <= 1'b0;
      r_illegal      <= 1'b0;
      r_retire_count <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_cls     <= (i_opcode == OPC_OP && i_funct7_0 && ENABLE_MULDIV) ? CL_MULDIV : w_dec.cls;
        r_alu_src <= w_dec.alu_src;
        r_alu_op  <= w_dec.alu_op;
        r_wsrc    <= w_dec.wsrc;
        r_jal     <= w_dec.jal;
        r_jalr    <= w_dec.jalr;
        r_auipc   <= w_dec.auipc;
        if (!w_dec.legal) r_illegal <= 1'b1;
      end else if (o_pc_write) begin
        r_cls     <= CL_ALU;
        r_alu_src <= 1'b0;
        r_alu_op  <= 2'b00;
        r_wsrc    <= 2'b00;
        r_jal     <= 1'b0;
        r_jalr    <= 1'b0;
        r_auipc   <= 1'b0;
      end
      if (o_pc_write) r_retire_count <= r_retire_count + RETIRE_W'(1);
    end
  end

  assign o_alu_src       = r_alu_src;
  assign o_alu_op        = r_alu_op;
  assign o_regwrite_src  = r_wsrc;
  assign o_jal           = r_jal;
  assign o_jalr          = r_jalr;
  assign o_auipc         = r_auipc;
  assign o_illegal_instr = r_illegal;
  assign o_retire_count  = r_retire_count;

endmodule
